// File: rtl/trigger_period_meter.sv
// trigger_period_meter
// Measures the clk-cycle distance between successive rising edges of a
// same-domain trigger and hands each measurement to a consumer over a
// valid/ready interface. It also keeps a wrapping edge counter, a no-edge
// timeout flag and a sticky overrun flag for measurements that had to be dropped.
module trigger_period_meter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             saturated,
    output logic [7:0]       edge_count,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    // Counter value whose increment would reach TIMEOUT.
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             trig_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             sat_q, sat_d;
    logic [7:0]       edge_cnt_q, edge_cnt_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;

    logic             edge_s;
    logic             capture_s;
    logic             transfer_s;

    assign edge_s     = trigger & ~trig_q;
    assign transfer_s = valid_q & period_ready;

    // State register of the measurement FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an edge always (re)starts a measurement, a timeout returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (edge_s) begin
                    state_d = ST_MEASURE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: counter, capture, handshake and flag updates.
    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        sat_d      = sat_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        capture_s  = 1'b0;
        valid_d    = transfer_s ? 1'b0 : valid_q;
        edge_cnt_d = edge_s ? (edge_cnt_q + 8'd1) : edge_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (edge_s) begin
                    cnt_d     = CNT_ONE;
                    timeout_d = 1'b0;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            ST_MEASURE: begin
                if (edge_s) begin
                    capture_s = 1'b1;
                    cnt_d     = CNT_ONE;
                    timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = CNT_ZERO;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = CNT_MAX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d = CNT_ZERO;
            end
        endcase

        // A capture lands only if the output slot is free or is being emptied this cycle.
        if (capture_s) begin
            if (!valid_q || transfer_s) begin
                period_d = cnt_q;
                sat_d    = (cnt_q == CNT_MAX);
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            period_d = period_q;
        end
    end

    // Datapath and flag registers; all outputs come straight from these.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q     <= 1'b0;
            cnt_q      <= CNT_ZERO;
            period_q   <= CNT_ZERO;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
            edge_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            trig_q     <= trigger;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
            edge_cnt_q <= edge_cnt_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign saturated    = sat_q;
    assign edge_count   = edge_cnt_q;
    assign timeout      = timeout_q;
    assign overrun      = overrun_q;

endmodule
